// File: rtl/driver_adc_if.sv
// Serial ADC link plus the captured-sample outputs of driver_adc.
// master is the driver side; slave is the ADC/consumer side.
interface driver_adc_if;
  logic       ADC_En;
  logic       ADC_Din;
  logic       ADC_CS;
  logic       ADC_SCLK;
  logic [7:0] ADC_Data;
  logic       ADC_Valid;
  logic       Frame_Err;
  logic       ADC_Busy;

  modport master (
    input  ADC_En, ADC_Din,
    output ADC_CS, ADC_SCLK, ADC_Data, ADC_Valid, Frame_Err, ADC_Busy
  );

  modport slave (
    output ADC_En, ADC_Din,
    input  ADC_CS, ADC_SCLK, ADC_Data, ADC_Valid, Frame_Err, ADC_Busy
  );
endinterface

// File: rtl/driver_adc.sv
// Serial ADC frame reader: 16-bit frames (3 leading zeros, 8 data bits, 5 ignored),
// continuous conversions while ADC_En is high, with a quiet gap between frames.
module driver_adc #(
  parameter int SCLK_DIV     = 5,
  parameter int QUIET_CYCLES = 50
) (
  input  logic          clk_100MHz,
  input  logic          Rst,
  driver_adc_if.master  bus
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, QUIET} state_t;

  localparam logic [9:0] DIV_LAST   = 10'(SCLK_DIV - 1);
  localparam logic [9:0] QUIET_LAST = 10'(QUIET_CYCLES - 1);

  state_t      state_reg;
  logic [9:0]  cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic [15:0] shift_reg;
  logic        cs_reg;
  logic        sclk_reg;
  logic        valid_reg;
  logic        err_reg;
  logic        busy_reg;
  logic [7:0]  data_reg;

  always_ff @(posedge clk_100MHz or negedge Rst) begin
    if (!Rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      cs_reg      <= 1'b1;
      sclk_reg    <= 1'b1;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      data_reg    <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.ADC_En) begin
            state_reg <= START;
            cs_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == DIV_LAST) begin
            state_reg   <= SHIFT;
            sclk_reg    <= 1'b0;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        SHIFT: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= '0;
            if (!sclk_reg) begin
              // Din was launched on the previous falling edge; capture as SCLK rises.
              sclk_reg    <= 1'b1;
              shift_reg   <= {shift_reg[14:0], bus.ADC_Din};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end else if (bit_cnt_reg == 5'd16) begin
              // Last high half-period finished: frame is complete.
              state_reg <= DONE;
              cs_reg    <= 1'b1;
              valid_reg <= 1'b1;
              data_reg  <= shift_reg[12:5];
              err_reg   <= |shift_reg[15:13];
            end else begin
              sclk_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        DONE: begin
          state_reg <= QUIET;
          cnt_reg   <= '0;
        end
        QUIET: begin
          if (cnt_reg == QUIET_LAST) begin
            cnt_reg <= '0;
            if (bus.ADC_En) begin
              state_reg <= START;
              cs_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 10'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cs_reg    <= 1'b1;
          sclk_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.ADC_CS    = cs_reg;
  assign bus.ADC_SCLK  = sclk_reg;
  assign bus.ADC_Data  = data_reg;
  assign bus.ADC_Valid = valid_reg;
  assign bus.Frame_Err = err_reg;
  assign bus.ADC_Busy  = busy_reg;

endmodule

// File: tb/tb_driver_adc.sv
// Bench for driver_adc: an ADC serving 16-bit frames, a frame-position model of
// the expected outputs checked every cycle, directed scenarios and random traffic.
module tb_driver_adc;

  localparam int D  = 5;
  localparam int Q  = 50;
  localparam int FL = 33 * D;

  logic clk_100MHz = 1'b0;
  logic Rst        = 1'b0;

  driver_adc_if bus ();

  driver_adc #(.SCLK_DIV(D), .QUIET_CYCLES(Q)) dut (
    .clk_100MHz (clk_100MHz),
    .Rst        (Rst),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Word the ADC will serve for the next frame; frame_word is the one in flight.
  logic [15:0] serve_word = 16'h0000;
  logic [15:0] frame_word = 16'h0000;

  // ADC: launch the next frame bit after each SCLK fall, rewind when CS rises.
  int adc_idx = 0;
  always @(negedge bus.ADC_SCLK or posedge bus.ADC_CS) begin
    if (bus.ADC_CS) begin
      adc_idx <= 0;
    end else begin
      bus.ADC_Din <= frame_word[15 - adc_idx];
      adc_idx     <= adc_idx + 1;
    end
  end

  // Model: position within the frame (-1 = idle). 0..FL-1 CS low, FL = done, then quiet.
  int         pos = -1;
  logic [7:0] exp_data = 8'h00;
  logic       exp_err  = 1'b0;
  always @(posedge clk_100MHz or negedge Rst) begin
    if (!Rst) begin
      pos      <= -1;
      exp_data <= 8'h00;
      exp_err  <= 1'b0;
    end else if (pos < 0 || pos == FL + Q) begin
      if (bus.ADC_En) begin
        pos        <= 0;
        frame_word <= serve_word;
      end else begin
        pos <= -1;
      end
    end else begin
      pos <= pos + 1;
      if (pos + 1 == FL) begin
        exp_data <= frame_word[12:5];
        exp_err  <= |frame_word[15:13];
      end
    end
  end

  int cyc = 0;
  int rises = 0;
  int vcnt = 0;
  int cs_low_cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;
  always @(posedge bus.ADC_SCLK) if (!bus.ADC_CS) rises <= rises + 1;

  always @(negedge clk_100MHz) begin
    if (bus.ADC_Valid) begin
      vcnt <= vcnt + 1;
      $display("frame cyc=%0d data=%02h err=%0b", cyc, bus.ADC_Data, bus.Frame_Err);
    end
    if (!bus.ADC_CS) cs_low_cyc <= cs_low_cyc + 1;
  end

  always @(negedge clk_100MHz) begin
    if (chk_on) begin
      logic exp_cs, exp_sclk;
      exp_cs   = !(pos >= 0 && pos < FL);
      exp_sclk = (pos >= D && pos < FL) ? 1'(((pos - D) / D) % 2) : 1'b1;
      chk("cs",    32'(bus.ADC_CS),    32'(exp_cs));
      chk("sclk",  32'(bus.ADC_SCLK),  32'(exp_sclk));
      chk("valid", 32'(bus.ADC_Valid), 32'(pos == FL));
      chk("busy",  32'(bus.ADC_Busy),  32'(pos >= 0));
      chk("data",  32'(bus.ADC_Data),  32'(exp_data));
      chk("err",   32'(bus.Frame_Err), 32'(exp_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  // Leaves the caller at the negedge where ADC_Valid is high.
  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    @(negedge clk_100MHz);
    while (!bus.ADC_Valid && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (!bus.ADC_Valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_cs_low(input int budget);
    int n = 0;
    @(negedge clk_100MHz);
    while (bus.ADC_CS && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (bus.ADC_CS) chk("cs_low_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk_100MHz);
    while (bus.ADC_Busy && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (bus.ADC_Busy) chk("idle_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic pulse_en();
    @(posedge clk_100MHz); #1;
    bus.ADC_En = 1'b1;
    @(posedge clk_100MHz); #1;
    bus.ADC_En = 1'b0;
  endtask

  initial begin
    int r0, v0, v1, c0, n;
    bus.ADC_En = 1'b1;
    tick(2);
    chk_on = 1'b1;
    // Held in reset with enable high: nothing may move.
    tick(10);
    chk("rst_cs", 32'(bus.ADC_CS), 32'd1);
    chk("rst_data", 32'(bus.ADC_Data), 32'h00);
    bus.ADC_En = 1'b0;
    Rst = 1'b1;
    tick(5);

    // Single pulsed conversion of 0xA5.
    serve_word = 16'h14A0;
    r0 = rises; v0 = vcnt;
    pulse_en();
    wait_valid(400, "a5");
    chk("a5_data", 32'(bus.ADC_Data), 32'hA5);
    chk("a5_err", 32'(bus.Frame_Err), 32'd0);
    wait_idle(200);
    chk("a5_rises", 32'(rises - r0), 32'd16);
    chk("a5_valids", 32'(vcnt - v0), 32'd1);

    // Back-to-back frames 0x00 then 0xFF.
    serve_word = 16'h0000;
    bus.ADC_En = 1'b1;
    wait_valid(400, "zero");
    v1 = cyc;
    chk("zero_data", 32'(bus.ADC_Data), 32'h00);
    serve_word = 16'h1FE0;
    n = 1;
    @(negedge clk_100MHz);
    while (bus.ADC_CS && n < 100) begin
      n++;
      @(negedge clk_100MHz);
    end
    chk("gap_cs_high", 32'(n), 32'd51);
    wait_valid(400, "ff");
    chk("ff_period", 32'(cyc - v1), 32'd216);
    chk("ff_data", 32'(bus.ADC_Data), 32'hFF);
    tick(1);
    bus.ADC_En = 1'b0;
    wait_idle(400);

    // Leading-zero violation, then a clean frame with the same data.
    serve_word = 16'h4780;
    pulse_en();
    wait_valid(400, "bad");
    chk("bad_data", 32'(bus.ADC_Data), 32'h3C);
    chk("bad_err", 32'(bus.Frame_Err), 32'd1);
    wait_idle(200);
    serve_word = 16'h0780;
    pulse_en();
    wait_valid(400, "clean");
    chk("clean_data", 32'(bus.ADC_Data), 32'h3C);
    chk("clean_err", 32'(bus.Frame_Err), 32'd0);
    wait_idle(200);

    // Enable dropped during the 5th SCLK period: frame still completes, then stop.
    serve_word = 16'h0B60;
    tick(1);
    bus.ADC_En = 1'b1;
    wait_cs_low(20);
    tick(48);
    bus.ADC_En = 1'b0;
    wait_valid(300, "drop");
    chk("drop_data", 32'(bus.ADC_Data), 32'h5B);
    wait_idle(200);
    c0 = cs_low_cyc;
    tick(400);
    chk("drop_no_cs", 32'(cs_low_cyc - c0), 32'd0);
    chk("drop_busy", 32'(bus.ADC_Busy), 32'd0);

    // Reset during the 9th SCLK period, then a full frame after release.
    serve_word = 16'h1FE0;
    bus.ADC_En = 1'b1;
    wait_cs_low(20);
    tick(88);
    v0 = vcnt;
    Rst = 1'b0;
    #1;
    chk("arst_cs", 32'(bus.ADC_CS), 32'd1);
    chk("arst_sclk", 32'(bus.ADC_SCLK), 32'd1);
    chk("arst_data", 32'(bus.ADC_Data), 32'h00);
    tick(3);
    chk("arst_no_valid", 32'(vcnt - v0), 32'd0);
    serve_word = 16'h14A0;
    Rst = 1'b1;
    wait_valid(400, "post_rst");
    chk("post_rst_data", 32'(bus.ADC_Data), 32'hA5);
    tick(1);
    bus.ADC_En = 1'b0;
    wait_idle(400);

    // Random traffic against the model.
    for (int i = 0; i < 25; i++) begin
      int mode;
      serve_word = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        pulse_en();
      end else if (mode == 1) begin
        bus.ADC_En = 1'b1;
        tick(int'($urandom_range(1, 500)));
        serve_word = 16'($urandom);
        tick(int'($urandom_range(1, 200)));
        bus.ADC_En = 1'b0;
      end else if (mode == 2) begin
        bus.ADC_En = 1'b1;
        tick(int'($urandom_range(1, 200)));
        Rst = 1'b0;
        tick(int'($urandom_range(1, 3)));
        Rst = 1'b1;
        bus.ADC_En = 1'b0;
      end
      tick(int'($urandom_range(0, 300)));
    end
    bus.ADC_En = 1'b0;
    tick(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/driver_adc.md
DRIVER_ADC -- requirements
Module: driver_adc

Interface
REQ-001 Parameter SCLK_DIV, default 5, clk_100MHz cycles per ADC_SCLK half-period; legal range 1..255.
REQ-002 Parameter QUIET_CYCLES, default 50, clk_100MHz cycles ADC_CS is held high between frames; legal range 1..1023.
REQ-003 clk_100MHz  input  1  system clock; all logic on rising edge.
REQ-004 Rst  input  1  reset, asynchronous assert, active-low.
REQ-005 ADC_En  input  1  level enable; high requests continuous conversions.
REQ-006 ADC_Din  input  1  serial data from ADC, MSB-first; changes after ADC_SCLK falling edge.
REQ-007 ADC_CS  output  1  ADC chip select, active-low, registered.
REQ-008 ADC_SCLK  output  1  ADC serial clock, idles high, registered.
REQ-009 ADC_Data  output  8  last captured sample, registered.
REQ-010 ADC_Valid  output  1  one-cycle pulse when ADC_Data updates.
REQ-011 Frame_Err  output  1  leading-zero check failed for the frame in ADC_Data.
REQ-012 ADC_Busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame format shall be 16 bits: bits 0-2 leading zeros, bits 3-10 data[7:0] MSB-first, bits 11-15 ignored.
REQ-014 State machine shall have states IDLE, START, SHIFT, DONE, QUIET.
REQ-015 IDLE: ADC_CS=1, ADC_SCLK=1; if ADC_En=1, next state START.
REQ-016 START: ADC_CS=0, ADC_SCLK=1 for exactly SCLK_DIV cycles, then SHIFT.
REQ-017 SHIFT: ADC_SCLK shall go low on entry and toggle every SCLK_DIV cycles, producing exactly 16 low-high periods with ADC_CS=0.
REQ-018 ADC_Din shall be sampled on the clk_100MHz edge that drives ADC_SCLK 0->1; bit counter (5-bit) increments per sample.
REQ-019 After the 16th sample, ADC_SCLK shall remain high and next state shall be DONE.
REQ-020 DONE (1 cycle): ADC_CS=1, ADC_Data and Frame_Err load from shift register, ADC_Valid=1.
REQ-021 Frame_Err shall be 1 if any of bits 0-2 was 1; ADC_Data still loads; both hold until next DONE.
REQ-022 QUIET: ADC_CS=1, ADC_SCLK=1 for QUIET_CYCLES cycles; then START if ADC_En=1, else IDLE.
REQ-023 Frame period with ADC_En held high shall be SCLK_DIV*33+1+QUIET_CYCLES cycles (216 at defaults).
REQ-024 ADC_En sampled only in IDLE and at QUIET exit; deassertion mid-frame shall not abort the frame.
REQ-025 ADC_Valid shall never be asserted outside DONE; no partial frame shall update ADC_Data.
REQ-026 ADC_Din shall be used without a synchronizer (ADC timing is derived from ADC_SCLK).

Reset
REQ-027 While Rst=0: state IDLE, ADC_CS=1, ADC_SCLK=1, ADC_Data=0, ADC_Valid=0, Frame_Err=0, ADC_Busy=0, counters and shift register 0.
REQ-028 Rst assertion mid-frame shall immediately (asynchronously) force ADC_CS=1 and ADC_SCLK=1, discarding the partial frame.
REQ-029 After Rst release, first START shall occur no earlier than the cycle after ADC_En is seen high in IDLE.

Verification
REQ-030 Rst=0 for 10 cycles with ADC_En=1 -> ADC_CS=1, ADC_SCLK=1, ADC_Data=0x00, ADC_Valid=0, ADC_Busy=0 throughout.
REQ-031 ADC model serves 000_10100101_00000, ADC_En pulsed 1 cycle -> exactly 16 ADC_SCLK rising edges while ADC_CS=0, one ADC_Valid pulse, ADC_Data=0xA5, Frame_Err=0, return to IDLE.
REQ-032 ADC_En held high, model serves 0x00 then 0xFF -> ADC_Valid pulses 216 cycles apart, ADC_Data 0x00 then 0xFF, ADC_CS high for 51 cycles between frames.
REQ-033 Model serves 010_00111100_00000 -> ADC_Data=0x3C, Frame_Err=1; next clean frame 0x3C clears Frame_Err=0.
REQ-034 ADC_En dropped during 5th SCLK period -> frame completes with ADC_Valid, then QUIET, then IDLE with no further ADC_CS low.
REQ-035 Rst asserted during 9th SCLK period -> ADC_CS=1 same cycle, no ADC_Valid, ADC_Data=0; after release with ADC_En=1 a full correct frame follows.
